// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac
//   3x3 sliding-window convolution with a 9-entry writable signed kernel.
//   Three row pixels arrive per valid beat (oldest row on row_top, raw
//   stream on row_bot). The window shifts left one column per beat, and the
//   result leaves a four-edge pipeline:
//     edge 1  window update + completeness tag
//     edge 2  nine signed products
//     edge 3  three row partial sums
//     edge 4  total, arithmetic shift, clip -> dout/valid_out
//   Optional macro CONV3X3_RELU_EN: clip to [0, 2^WIDTH-1] (unsigned output).
//   Default (macro undefined): saturate to the signed WIDTH-bit range.
//
// Ports
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   row_top/mid/bot three vertically aligned pixels (unsigned, WIDTH bits)
//   valid_in        all three row pixels valid this cycle
//   coef_wr/addr/data  kernel write port, index 0..8 row-major, 9..15 ignored
//   dout, valid_out registered convolution result and its strobe
//   frame_done      pulse with the last valid_out of a frame
module conv3x3_window_mac #(
  parameter int WIDTH      = 16,
  parameter int IMG_WIDTH  = 480,
  parameter int IMG_HEIGHT = 272,
  parameter int COEF_WIDTH = 8,
  parameter int SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic        [WIDTH-1:0]      row_top,
  input  logic        [WIDTH-1:0]      row_mid,
  input  logic        [WIDTH-1:0]      row_bot,
  input  logic                         valid_in,
  input  logic                         coef_wr,
  input  logic        [3:0]            coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic        [WIDTH-1:0]      dout,
  output logic                         valid_out,
  output logic                         frame_done
);

  localparam int PW = WIDTH + 1 + COEF_WIDTH;  // full-precision product
  localparam int SW = PW + 4;                  // 9-term sum with guard bits
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic signed [SW-1:0] SMAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] UMAX = {{(SW-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  // Pixel is zero-extended to a positive signed value before multiplying.
  function automatic logic signed [PW-1:0] mul_px(input logic [WIDTH-1:0] px,
                                                  input logic signed [COEF_WIDTH-1:0] cf);
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    a = PW'($signed({1'b0, px}));
    b = PW'(cf);
    return a * b;
  endfunction

  function automatic logic [WIDTH-1:0] clip_out(input logic signed [SW-1:0] v);
`ifdef CONV3X3_RELU_EN
    if (v[SW-1])      return '0;
    else if (v > UMAX) return '1;
    else               return v[WIDTH-1:0];
`else
    if (v > SMAX)      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (v < SMIN) return {1'b1, {(WIDTH-1){1'b0}}};
    else               return v[WIDTH-1:0];
`endif
  endfunction

  logic        [CW-1:0]         col_q, col_d;
  logic        [RW-1:0]         row_q, row_d;
  logic        [WIDTH-1:0]      win_p0_q [3][3];  // [row: 0=top][col: 0=left]
  logic signed [COEF_WIDTH-1:0] coef_q   [9];
  logic                         vld_p0_q, last_p0_q;
  logic signed [PW-1:0]         prod_p1_q [9];
  logic                         vld_p1_q, last_p1_q;
  logic signed [SW-1:0]         rsum_p2_q [3];
  logic                         vld_p2_q, last_p2_q;
  logic signed [SW-1:0]         total;
  logic signed [SW-1:0]         shifted;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_HEIGHT - 3)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // ---- edge 1: window shift, counters, completeness tag, kernel writes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      vld_p0_q  <= 1'b0;
      last_p0_q <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_p0_q[r][c] <= '0;
      for (int i = 0; i < 9; i++)
        coef_q[i] <= (i == 4) ? COEF_WIDTH'(1) : '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      // The first two columns of a row only prime the window.
      vld_p0_q  <= valid_in && (col_q >= CW'(2));
      last_p0_q <= valid_in && (col_q == CW'(IMG_WIDTH - 1)) &&
                   (row_q == RW'(IMG_HEIGHT - 3));
      if (valid_in) begin
        for (int r = 0; r < 3; r++) begin
          win_p0_q[r][0] <= win_p0_q[r][1];
          win_p0_q[r][1] <= win_p0_q[r][2];
        end
        win_p0_q[0][2] <= row_top;
        win_p0_q[1][2] <= row_mid;
        win_p0_q[2][2] <= row_bot;
      end
      for (int i = 0; i < 9; i++)
        if (coef_wr && (coef_addr == 4'(i)))
          coef_q[i] <= coef_data;
    end
  end

  // ---- edge 2: products ----
  always_ff @(posedge clk) begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        prod_p1_q[r*3+c] <= mul_px(win_p0_q[r][c], coef_q[r*3+c]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p0_q;
      last_p1_q <= last_p0_q;
    end
  end

  // ---- edge 3: row partial sums ----
  always_ff @(posedge clk) begin
    for (int r = 0; r < 3; r++)
      rsum_p2_q[r] <= SW'(prod_p1_q[r*3]) + SW'(prod_p1_q[r*3+1]) +
                      SW'(prod_p1_q[r*3+2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
    end else begin
      vld_p2_q  <= vld_p1_q;
      last_p2_q <= last_p1_q;
    end
  end

  // ---- edge 4: total, shift, clip ----
  assign total   = rsum_p2_q[0] + rsum_p2_q[1] + rsum_p2_q[2];
  assign shifted = total >>> SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= vld_p2_q;
      frame_done <= vld_p2_q && last_p2_q;
      if (vld_p2_q)
        dout <= clip_out(shifted);
    end
  end

endmodule

// File: doc/conv3x3_window_mac.md
CONV3X3_WINDOW_MAC -- requirements
Module: conv3x3_window_mac

Interface
REQ-001 Parameter WIDTH, 16: pixel width; pixels unsigned.
REQ-002 Parameter IMG_WIDTH, 480: pixels per image row.
REQ-003 Parameter IMG_HEIGHT, 272: rows per frame.
REQ-004 Parameter COEF_WIDTH, 8: signed kernel coefficient width.
REQ-005 Parameter SHIFT, 0: arithmetic right shift applied to the 9-term sum before clipping.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 row_top  input  WIDTH  oldest row pixel, from the second line-buffer output.
REQ-009 row_mid  input  WIDTH  middle row pixel, from the first line-buffer output.
REQ-010 row_bot  input  WIDTH  newest row pixel, the raw stream pixel.
REQ-011 valid_in  input  1  all three row pixels valid this cycle; driven by the last line-buffer valid_out.
REQ-012 coef_wr  input  1  coefficient write strobe.
REQ-013 coef_addr  input  4  coefficient index 0..8, row-major, 0 = top-left; 9..15 ignored.
REQ-014 coef_data  input  COEF_WIDTH  signed coefficient value.
REQ-015 dout  output  WIDTH  convolution result, registered.
REQ-016 valid_out  output  1  dout valid, registered.
REQ-017 frame_done  output  1  one-cycle pulse coincident with the last valid_out of a frame.

Function
REQ-018 On each valid_in cycle, the 3x3 window SHALL shift left one column and load {row_top,row_mid,row_bot} into the right column; otherwise it SHALL hold.
REQ-019 col_cnt SHALL count valid_in beats 0..IMG_WIDTH-1, wrap to 0, and increment row_cnt on wrap; row_cnt SHALL wrap to 0 after IMG_HEIGHT-3.
REQ-020 A window SHALL be marked complete only when valid_in is sampled with col_cnt>=2, giving IMG_WIDTH-2 outputs per row and no windows spanning two rows.
REQ-021 Pipeline: edge 1 updates window and tags completeness, edge 2 registers 9 signed products, edge 3 registers 3 row partial sums, edge 4 registers total, shift and clip into dout/valid_out.
REQ-022 valid_out SHALL rise on the 4th rising edge, counting the edge that samples the completing pixel as the 1st; throughput is one result per valid_in beat, and gaps SHALL NOT alter results.
REQ-023 Each product SHALL be the zero-extended pixel (WIDTH+1 bits, signed) times the coefficient, full precision, and the sum SHALL carry 4 guard bits with no intermediate overflow.
REQ-024 A coef_wr with coef_addr<=8 SHALL update that coefficient at the sampling edge, and products registered on later edges SHALL use the new value; mid-stream writes are legal.
REQ-025 frame_done SHALL assert with valid_out for col_cnt=IMG_WIDTH-1 at row_cnt=IMG_HEIGHT-3.
REQ-026 No backpressure: the block SHALL accept valid_in every cycle.

Reset
REQ-027 While rst is high at an edge: valid_out=0, frame_done=0, dout=0, col_cnt=0, row_cnt=0, all pipeline valid tags=0, window=0.
REQ-028 Reset SHALL load the identity kernel: coefficient 4 = 1, all others 0.
REQ-029 Reset mid-frame SHALL discard all in-flight results; no valid_out is produced for pixels sampled before the reset.

Configuration
REQ-030 Macro CONV3X3_RELU_EN defined: the shifted sum SHALL be clipped to [0, 2^WIDTH-1] and output unsigned, so negatives give 0.
REQ-031 Macro CONV3X3_RELU_EN undefined: the shifted sum SHALL saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and output in two's complement.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, SHIFT=0)
REQ-032 After reset, stream row_mid = 10*col (cols 0..7) gaplessly: the first valid_out comes on the 4th edge after col 2 is sampled, with dout=10, then 20..60; 6 outputs per row.
REQ-033 Write all 9 coefs = 1, all pixels = 100: every dout = 900; 24 outputs per frame; frame_done on the 24th.
REQ-034 All coefs = -1, pixels = 5: dout=0 with RELU_EN; dout=16'hFFD3 (-45) without it.
REQ-035 All coefs = 127, pixels = 65535: dout=65535 with RELU_EN; dout=32767 without it.
REQ-036 Random valid_in gaps (~50% duty) on the REQ-033 stream: identical dout sequence, and each valid_out stays 4 edges after its completing sample.
REQ-037 Assert rst for 1 cycle at row 1, col 4: valid_out=0 next cycle, no stale outputs, kernel identity, and the next stream restarts at col 0.
